adc_spi_sampler: RTL
====================

Name: adc_spi_sampler

Overview:
- Upstream front-end of spike_detection_avalon.
- Periodically drives a serial (SPI mode 0) ADC, deserialises one 16-bit word per conversion, and presents it on sample_o/sample_valid_o. These outputs connect directly to the detector's sample_i/sample_valid_i.
- Conversions run only while enable_i is high. The detector's acquisition-start control drives enable_i.

Parameters:
- DATA_W, 16, sample width; also the number of SCLK bits per conversion.
- CLK_DIV, 4, SCLK half-period in avl_clk_i cycles; must be >= 1.
- SAMPLE_PERIOD, 200, avl_clk_i cycles between consecutive cs_n falling edges; must be >= 2*DATA_W*CLK_DIV + 2*CLK_DIV + 1.

Ports:
- avl_clk_i  in  1  system clock.
- avl_reset_i  in  1  synchronous, active-low reset.
- enable_i  in  1  acquisition enable (level).
- adc_cs_n_o  out  1  ADC chip select, active low.
- adc_sclk_o  out  1  ADC serial clock, idle low.
- adc_miso_i  in  1  ADC serial data, MSB first.
- sample_o  out  DATA_W  last captured sample; held until next capture.
- sample_valid_o  out  1  one-cycle strobe, sample_o is new.
- busy_o  out  1  conversion in progress (any state except IDLE and WAIT).

Behaviour:
- Reset (avl_reset_i low at a rising edge) has priority over everything. It forces:
  - adc_cs_n_o=1, adc_sclk_o=0
  - sample_o=0, sample_valid_o=0, busy_o=0
  - state IDLE, all counters 0
- Reset mid-conversion aborts it; no sample is emitted.
- All outputs are registered. D denotes CLK_DIV; T0 is the first cycle with adc_cs_n_o=0.
- FSM states: IDLE, SETUP, SHIFT, HOLD, DONE, WAIT.
  - IDLE: when enable_i=1 go to SETUP next cycle.
  - SETUP: D cycles; cs_n=0, sclk=0.
  - SHIFT: 2*DATA_W*D cycles.
    - adc_sclk_o toggles every D cycles, rising first at T0+D. Rising edges fall at T0+D*(1+2k), k=0..DATA_W-1.
    - On each cycle where sclk_o is registered 0->1, adc_miso_i is shifted into the LSB of the shift register (MSB first).
  - HOLD: D cycles; cs_n=0, sclk=0.
  - DONE: 1 cycle.
    - adc_cs_n_o=1, sample_o<=shift register, sample_valid_o=1 at T0+(2*DATA_W+2)*D. This is 136 cycles for the defaults.
    - If enable_i=1 go to WAIT, else IDLE.
  - WAIT: cs_n=1. Go to SETUP when the period counter (started at T0) reaches SAMPLE_PERIOD-1, so the next T0 is exactly T0+SAMPLE_PERIOD. If enable_i drops in WAIT, go to IDLE next cycle.
- enable_i dropping during SETUP/SHIFT/HOLD does not abort. The conversion completes, the sample is emitted, then the FSM goes to IDLE.
- Re-enable from IDLE restarts timing: T0 is 2 cycles after enable_i is sampled high (one cycle to leave IDLE, SETUP output registered).
- sample_valid_o is never high for 2 consecutive cycles.
- sample_o changes only in the cycle sample_valid_o is high.
- adc_sclk_o is 0 whenever adc_cs_n_o=1.

Optional Feature:
- Macro: ADC_SAMPLER_TWOS_COMP_EN.
- Defined: the ADC word is offset-binary; sample_o = shift register with MSB inverted. Example: 16'h8000 -> 16'h0000, 16'h0000 -> 16'h8000.
- Undefined: sample_o = shift register unchanged.

Test Plan:
- Reset with enable_i=1 held 10 cycles -> cs_n=1, sclk=0, sample_o=0, valid=0 throughout. First cs_n fall 2 cycles after reset released.
- Defaults, ADC model returns 16'hA5C3 -> exactly 16 sclk rising edges, 4 clk high/4 low each. valid pulse at T0+136 with sample_o=16'hA5C3 (16'h25C3 with ADC_SAMPLER_TWOS_COMP_EN).
- Continuous enable, ADC model returns 1,2,3,... -> cs_n falling edges exactly 200 cycles apart. Valid pulses carry 1,2,3 in order, each 1 cycle wide.
- enable_i dropped at T0+50 -> conversion completes, valid at T0+136, then IDLE with cs_n=1 and no further conversion.
- Reset asserted at T0+70 -> no valid pulse, cs_n=1 and sclk=0 on the next edge. sample_o keeps 0 (or is forced to 0).
- CLK_DIV=1, SAMPLE_PERIOD=35 -> back-to-back conversions with valid every 35 cycles and correct data; no sclk glitch across the DONE/WAIT/SETUP boundary.

Source files
------------

// File: rtl/adc_spi_sampler.sv
// -----------------------------------------------------------------------------
// adc_spi_sampler
//
// Purpose:
//    Front-end sampler for spike_detection_avalon. While enable_i is high it
//    runs one SPI mode-0 conversion every SAMPLE_PERIOD clocks. Each conversion
//    clocks DATA_W bits out of a serial ADC, MSB first, and presents the word
//    on sample_o with a one-cycle sample_valid_o strobe.
//
// Configuration macro:
//    ADC_SAMPLER_TWOS_COMP_EN - when defined, the ADC word is treated as
//    offset-binary. It is converted to two's complement by inverting the MSB.
//    When undefined, the captured word is passed through unchanged.
//
// Parameters:
//    DATA_W        sample width and number of SCLK bits per conversion
//    CLK_DIV       SCLK half-period in avl_clk_i cycles (>= 1)
//    SAMPLE_PERIOD clocks between consecutive chip-select falling edges
//                  (>= 2*DATA_W*CLK_DIV + 2*CLK_DIV + 1)
//
// Ports:
//    avl_clk_i      in   system clock
//    avl_reset_i    in   synchronous reset, active low
//    enable_i       in   acquisition enable (level)
//    adc_cs_n_o     out  ADC chip select, active low
//    adc_sclk_o     out  ADC serial clock, idle low
//    adc_miso_i     in   ADC serial data, MSB first
//    sample_o       out  last captured sample, held until the next capture
//    sample_valid_o out  one-cycle strobe: sample_o has just been updated
//    busy_o         out  a conversion is in progress
//
// Timing note:
//    Every output is registered from the current state. The pins therefore
//    trail the state register by one cycle. The period counter and all
//    durations are measured on the state, so the pin timing is the same
//    pattern shifted by one cycle.
// -----------------------------------------------------------------------------
module adc_spi_sampler #(
   parameter int DATA_W        = 16,
   parameter int CLK_DIV       = 4,
   parameter int SAMPLE_PERIOD = 200
) (
   input  logic              avl_clk_i,
   input  logic              avl_reset_i,
   input  logic              enable_i,
   output logic              adc_cs_n_o,
   output logic              adc_sclk_o,
   input  logic              adc_miso_i,
   output logic [DATA_W-1:0] sample_o,
   output logic              sample_valid_o,
   output logic              busy_o
);

   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int EDGE_W = $clog2(2 * DATA_W);
   localparam int PER_W  = $clog2(SAMPLE_PERIOD);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);
   localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(SAMPLE_PERIOD - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_DONE,
      S_WAIT
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic [DIV_W-1:0]    r_div;      // cycles within the current SCLK half-period
   logic [EDGE_W-1:0]   r_edge;     // SCLK half-period index within SHIFT
   logic [PER_W-1:0]    r_period;   // cycles since the current conversion entered SETUP
   logic [DATA_W-1:0]   r_shift;

   logic                r_cs_n;
   logic                r_sclk;
   logic                r_valid;
   logic                r_busy;
   logic [DATA_W-1:0]   r_sample;

   logic                w_cs_n_next;
   logic                w_sclk_next;
   logic                w_valid_next;
   logic                w_busy_next;
   logic [DATA_W-1:0]   w_sample_next;
   logic [DATA_W-1:0]   w_word;

   logic                w_div_wrap;
   logic                w_state_change;
   logic                w_enter_setup;
   logic                w_capture;

   assign w_div_wrap     = (r_div == DIV_LAST);
   assign w_state_change = (w_state_next != r_state);
   assign w_enter_setup  = (w_state_next == S_SETUP) && (r_state != S_SETUP);
   // Sample MISO on the clock edge that registers SCLK from 0 to 1.
   assign w_capture      = w_sclk_next & ~r_sclk;

`ifdef ADC_SAMPLER_TWOS_COMP_EN
   assign w_word = {~r_shift[DATA_W-1], r_shift[DATA_W-2:0]};
`else
   assign w_word = r_shift;
`endif

   // State register, timing counters and shift register
   always_ff @(posedge avl_clk_i) begin
      if (!avl_reset_i) begin
         r_state  <= S_IDLE;
         r_div    <= '0;
         r_edge   <= '0;
         r_period <= '0;
         r_shift  <= '0;
      end else begin
         r_state <= w_state_next;

         // The divider restarts on every state change. SETUP, SHIFT and HOLD
         // therefore all begin on a half-period boundary.
         if (w_state_change) begin
            r_div  <= '0;
            r_edge <= '0;
         end else if (w_div_wrap) begin
            r_div  <= '0;
            r_edge <= r_edge + EDGE_W'(1);
         end else begin
            r_div  <= r_div + DIV_W'(1);
         end

         if (w_enter_setup) begin
            r_period <= '0;
         end else if ((r_state != S_IDLE) && (r_period != PER_LAST)) begin
            r_period <= r_period + PER_W'(1);
         end

         if (w_capture) begin
            r_shift <= {r_shift[DATA_W-2:0], adc_miso_i};
         end
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (enable_i) w_state_next = S_SETUP;
         end
         S_SETUP: begin
            if (w_div_wrap) w_state_next = S_SHIFT;
         end
         S_SHIFT: begin
            if (w_div_wrap && (r_edge == EDGE_LAST)) w_state_next = S_HOLD;
         end
         S_HOLD: begin
            if (w_div_wrap) w_state_next = S_DONE;
         end
         S_DONE: begin
            // At the minimum legal SAMPLE_PERIOD the period is already used up
            // here. In that case WAIT is skipped and the next conversion starts
            // at once.
            if (!enable_i)                   w_state_next = S_IDLE;
            else if (r_period == PER_LAST)   w_state_next = S_SETUP;
            else                             w_state_next = S_WAIT;
         end
         S_WAIT: begin
            if (!enable_i)                   w_state_next = S_IDLE;
            else if (r_period == PER_LAST)   w_state_next = S_SETUP;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Output decode (registered below)
   always_comb begin
      w_cs_n_next   = 1'b1;
      w_sclk_next   = 1'b0;
      w_valid_next  = 1'b0;
      w_busy_next   = 1'b0;
      w_sample_next = r_sample;
      case (r_state)
         S_SETUP, S_HOLD: begin
            w_cs_n_next = 1'b0;
            w_busy_next = 1'b1;
         end
         S_SHIFT: begin
            // SCLK is high on even half-periods, so the first half-period of
            // SHIFT is high and the last one is low.
            w_cs_n_next = 1'b0;
            w_busy_next = 1'b1;
            w_sclk_next = ~r_edge[0];
         end
         S_DONE: begin
            w_busy_next   = 1'b1;
            w_valid_next  = 1'b1;
            w_sample_next = w_word;
         end
         default: ;
      endcase
   end

   always_ff @(posedge avl_clk_i) begin
      if (!avl_reset_i) begin
         r_cs_n   <= 1'b1;
         r_sclk   <= 1'b0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
         r_sample <= '0;
      end else begin
         r_cs_n   <= w_cs_n_next;
         r_sclk   <= w_sclk_next;
         r_valid  <= w_valid_next;
         r_busy   <= w_busy_next;
         r_sample <= w_sample_next;
      end
   end

   assign adc_cs_n_o     = r_cs_n;
   assign adc_sclk_o     = r_sclk;
   assign sample_o       = r_sample;
   assign sample_valid_o = r_valid;
   assign busy_o         = r_busy;

endmodule
